cpu_debug_scan_master: RTL and testbench
========================================

// Module: cpu_debug_scan_master
// PURPOSE
//  Host-side initiator for the CPU debug-slave virtual-JTAG interface.
//  Converts one command into a complete virtual scan: IR update, DR capture, SR_WIDTH-bit DR shift, DR update and run-test-idle.
//  Drives the signals the debug slave consumes: tck, tdi, ir_in, cdr/sdr/udr/uir/rti.
//  Captures tdo and returns the shifted-out DR word as a response.
//  Used by on-chip test harnesses and simulation benches in place of the sld_virtual_jtag hub.
// PARAMETERS
//  SR_WIDTH  38  DR shift length in bits; >=2
//  IR_WIDTH  2   virtual IR width
//  TCK_DIV   2   clk cycles per tck half-period; >=1
// PORTS
//  clk          in   1         system clock; the only clock
//  reset_n      in   1         asynchronous active-low reset
//  cmd_valid    in   1         command offered
//  cmd_ready    out  1         command accepted when cmd_valid&cmd_ready at a rising clk edge
//  cmd_ir       in   IR_WIDTH  virtual IR value for this scan
//  cmd_dr       in   SR_WIDTH  DR value to shift in, LSB first
//  rsp_valid    out  1         response held until accepted
//  rsp_ready    in   1         response consumer ready
//  rsp_dr       out  SR_WIDTH  captured tdo bits; bit0 = first bit shifted out
//  tck          out  1         generated scan clock (registered)
//  tdi          out  1         serial data to slave
//  tdo          in   1         serial data from slave
//  ir_in        out  IR_WIDTH  virtual IR presented to slave
//  vs_uir       out  1         update-IR state
//  vs_cdr       out  1         capture-DR state
//  vs_sdr       out  1         shift-DR state
//  vs_udr       out  1         update-DR state
//  jtag_rti     out  1         run-test-idle state
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; tck=0, tdi=0; ir_in=0; all vs_*=0; jtag_rti=0.
//   - rsp_valid=0, rsp_dr=0; cmd_ready=1.
//  Command handshake:
//   - cmd_ready=1 only in IDLE with rsp_valid=0.
//   - On accept, latch cmd_ir/cmd_dr; enter UIR on the next clk.
//  tck generation:
//   - A half-period counter runs only outside IDLE/DONE.
//   - tck toggles every TCK_DIV clk cycles, starting low.
//   - One tck period = 2*TCK_DIV clk cycles.
//   - Each tck period begins with tck low.
//   - State and tdi change only at period boundaries, i.e. on tck falling edges.
//  FSM (one tck period per state unless noted):
//   - IDLE -> UIR: ir_in<=latched IR; vs_uir=1.
//   - UIR -> CDR: vs_cdr=1.
//   - CDR -> SDR: vs_sdr=1 for exactly SR_WIDTH periods.
//     - tdi = dr[k] in period k, k=0..SR_WIDTH-1.
//     - tdo is sampled on the clk where tck rises; sample k is written to rsp_dr[k].
//   - SDR -> UDR: vs_udr=1; tdi=0.
//   - UDR -> RTI: jtag_rti=1.
//   - RTI -> DONE: tck held 0; rsp_valid=1.
//   - DONE -> IDLE: when rsp_ready=1; rsp_valid drops on the same edge.
//   - Exactly one of vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_rti is high outside IDLE/DONE.
//  Latency:
//   - rsp_valid rises (SR_WIDTH+4)*2*TCK_DIV + 1 clk cycles after the accept edge.
//   - Default values give 169.
//  Holding rules:
//   - ir_in holds its last value between scans.
//   - rsp_dr holds until the next scan's first tdo sample.
//  Boundaries:
//   - cmd_valid while busy or while rsp_valid=1 -> cmd_ready=0; the command is not consumed.
//   - rsp_ready=1 already asserted in DONE -> single-cycle rsp_valid pulse.
//   - Back-to-back commands: accept is possible on the clk after DONE exits.
//   - reset_n low mid-scan -> immediate abort to reset values; no partial response is issued.
// TESTING
//  - Reset: reset_n=0 -> tck=0, all vs_*=0, cmd_ready=1, rsp_valid=0, ir_in=0.
//  - Loopback (tdo=tdi, delayed one tck), cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A
//    -> ir_in=01 during vs_uir; rsp_dr = cmd_dr shifted by one period; rsp_valid at 169 clks.
//  - tdo tied 1, cmd_dr=0 -> rsp_dr=38'h3F_FFFF_FFFF; tdi=0 for the whole scan;
//    vs_sdr high for exactly 38*4=152 clks.
//  - Second cmd_valid held high during a scan -> cmd_ready=0 until DONE exits and rsp_ready=1;
//    second scan then runs with its own IR/DR.
//  - rsp_ready=0 for 20 clks after DONE -> rsp_valid and rsp_dr stable; tck stays 0; no state strobes.
//  - reset_n pulsed low mid-SDR (bit 10) -> all outputs at reset values next clk;
//    the next command completes a normal scan.

Source files
------------

// File: rtl/cpu_debug_scan_master_if.sv
// Command/response and virtual-JTAG signal bundle for cpu_debug_scan_master.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge, and ready never depends on a transfer in that cycle.
interface cpu_debug_scan_master_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  // Command channel
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_dr;

  // Response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_dr;

  // Virtual scan signals towards the debug slave
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_udr;
  logic                jtag_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
    output cmd_ready, rsp_valid, rsp_dr,
    output tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
    input  cmd_ready, rsp_valid, rsp_dr,
    input  tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_rti
  );
endinterface

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: turns one command into UIR, CDR, SR_WIDTH-bit
// SDR, UDR and RTI phases (one tck period each, SDR one per bit) and returns
// the tdo bits captured during the shift as a response.
module cpu_debug_scan_master #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cpu_debug_scan_master_if.master bus,
  output logic [2:0]              state_dbg
);

  localparam int CNT_W = $clog2(2 * TCK_DIV);
  localparam int BIT_W = $clog2(SR_WIDTH);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(SR_WIDTH - 1);

  // S_LOAD is the single clk between the accept edge and the UIR period.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UIR  = 3'd2,
    S_CDR  = 3'd3,
    S_SDR  = 3'd4,
    S_UDR  = 3'd5,
    S_RTI  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                tck_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [SR_WIDTH-1:0] dr_sh;
  logic [SR_WIDTH-1:0] rsp_q;

  logic accept;
  logic active;
  logic tck_rise;
  logic period_end;
  logic uir_s, cdr_s, sdr_s, udr_s, rti_s;

  assign accept     = (state == S_IDLE) && bus.cmd_valid;
  assign active     = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                      (state == S_UDR) || (state == S_RTI);
  // tck goes high on the edge that ends the low half, and the period ends
  // (tck falls, state/tdi advance) on the edge that ends the high half.
  assign tck_rise   = active && (div_cnt == HALF_LAST);
  assign period_end = active && (div_cnt == PERIOD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and state-decoded strobes
  always_comb begin
    state_n = state;
    uir_s   = 1'b0;
    cdr_s   = 1'b0;
    sdr_s   = 1'b0;
    udr_s   = 1'b0;
    rti_s   = 1'b0;
    case (state)
      S_IDLE: if (accept) state_n = S_LOAD;
      S_LOAD: state_n = S_UIR;
      S_UIR: begin
        uir_s = 1'b1;
        if (period_end) state_n = S_CDR;
      end
      S_CDR: begin
        cdr_s = 1'b1;
        if (period_end) state_n = S_SDR;
      end
      S_SDR: begin
        sdr_s = 1'b1;
        if (period_end && (bit_cnt == BIT_LAST)) state_n = S_UDR;
      end
      S_UDR: begin
        udr_s = 1'b1;
        if (period_end) state_n = S_RTI;
      end
      S_RTI: begin
        rti_s = 1'b1;
        if (period_end) state_n = S_DONE;
      end
      S_DONE: if (bus.rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Half-period counter and registered tck; both parked at zero when not scanning
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else begin
      div_cnt <= period_end ? '0 : div_cnt + CNT_W'(1);
      if (tck_rise)        tck_q <= 1'b1;
      else if (period_end) tck_q <= 1'b0;
    end
  end

  // Command latch, DR shift register and bit counter for the SDR phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      dr_sh   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      ir_q    <= bus.cmd_ir;
      dr_sh   <= bus.cmd_dr;
      bit_cnt <= '0;
    end else if ((state == S_SDR) && period_end) begin
      dr_sh   <= dr_sh >> 1;
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Virtual IR presented to the slave; updated as the UIR period begins and held between scans
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               ir_in_q <= '0;
    else if (state == S_LOAD)   ir_in_q <= ir_q;
  end

  // tdo capture on the clk where tck rises; bit k of the response is the k-th sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          rsp_q          <= '0;
    else if ((state == S_SDR) && tck_rise) rsp_q[bit_cnt] <= bus.tdo;
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_dr    = rsp_q;
  assign bus.tck       = tck_q;
  assign bus.tdi       = sdr_s & dr_sh[0];
  assign bus.ir_in     = ir_in_q;
  assign bus.vs_uir    = uir_s;
  assign bus.vs_cdr    = cdr_s;
  assign bus.vs_sdr    = sdr_s;
  assign bus.vs_udr    = udr_s;
  assign bus.jtag_rti  = rti_s;
  assign state_dbg     = state;

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Bench for cpu_debug_scan_master: acts as the debug slave (drives tdo from a
// per-scan rule), checks phase timing, tdi stream, response word and handshakes.
module tb_cpu_debug_scan_master;

  localparam int SRW       = 38;
  localparam int IRW       = 2;
  localparam int DIV       = 2;
  localparam int PER       = 2 * DIV;
  localparam int SCAN_CLKS = (SRW + 4) * PER + 1;
  localparam int MODE_LOOP = 0;  // tdo = tdi of the previous tck period, 0 first
  localparam int MODE_ONES = 1;  // tdo tied high
  localparam int MODE_PAT  = 2;  // tdo in period k = pattern bit k

  typedef struct {
    logic [IRW-1:0] ir;
    logic [SRW-1:0] dr;
    int             mode;
    logic [SRW-1:0] pat;
    int             hold;
    logic [SRW-1:0] exp_rsp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  cpu_debug_scan_master_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) bus ();

  cpu_debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [SRW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: what the slave returns, given how it drives tdo
  function automatic logic [SRW-1:0] model_rsp(input int mode, input logic [SRW-1:0] dr,
                                               input logic [SRW-1:0] pat);
    case (mode)
      MODE_LOOP: return dr << 1;
      MODE_ONES: return '1;
      default:   return pat;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " ctl"},
          {bus.tck, bus.tdi, bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr,
           bus.jtag_rti, bus.rsp_valid, bus.cmd_ready},
          9'b0_0000_0001);
    check({tag, " ir_in"}, bus.ir_in, 0);
    check({tag, " rsp_dr"}, bus.rsp_dr, 0);
  endtask

  // ---------------- driver: one full scan ----------------
  // Called just after a falling clk edge. With chain=1 the next command
  // (nir/ndr) is offered right after the accept and kept valid.
  task automatic run_scan(input string tag, input logic [IRW-1:0] ir, input logic [SRW-1:0] dr,
                          input int mode, input logic [SRW-1:0] pat, input int hold,
                          input logic [SRW-1:0] exp_rsp, input bit chain,
                          input logic [IRW-1:0] nir, input logic [SRW-1:0] ndr);
    int wait_n, lat, hot, sdr_rises, all_rises;
    int c_uir, c_cdr, c_sdr, c_udr, c_rti;
    int bad_hot, bad_tdi, bad_ir, bad_rdy, bad_hold;
    logic prev_tck;
    logic [SRW-1:0] tdi_seen, snap, exp_w;

    exp_q.push_back(exp_rsp);
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    bus.rsp_ready = (hold == 0);
    bus.tdo       = 1'b0;

    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    if (!bus.cmd_ready) begin
      check({tag, " accept timeout"}, 0, 1);
      exp_w = exp_q.pop_front();
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);  // accept edge has passed
    if (chain) begin
      bus.cmd_ir = nir;
      bus.cmd_dr = ndr;
    end else begin
      bus.cmd_valid = 1'b0;
    end

    lat = 0; sdr_rises = 0; all_rises = 0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
    bad_hot = 0; bad_tdi = 0; bad_ir = 0; bad_rdy = 0; bad_hold = 0;
    tdi_seen = '0;
    prev_tck = bus.tck;
    while (!bus.rsp_valid && lat < 400) begin
      hot = int'(bus.vs_uir) + int'(bus.vs_cdr) + int'(bus.vs_sdr) + int'(bus.vs_udr) +
            int'(bus.jtag_rti);
      if (hot > 1) bad_hot++;
      if (bus.vs_uir) begin
        c_uir++;
        if (bus.ir_in !== ir) bad_ir++;
      end
      if (bus.vs_cdr)   c_cdr++;
      if (bus.vs_sdr)   c_sdr++;
      if (bus.vs_udr)   c_udr++;
      if (bus.jtag_rti) c_rti++;
      if (!bus.vs_sdr && bus.tdi !== 1'b0) bad_tdi++;
      if (bus.cmd_ready) bad_rdy++;
      if (bus.tck && !prev_tck) begin
        all_rises++;
        if (bus.vs_sdr) begin
          if (sdr_rises < SRW) tdi_seen[sdr_rises] = bus.tdi;
          sdr_rises++;
        end
      end
      prev_tck = bus.tck;
      // slave behaviour: value for the next SDR rising edge
      case (mode)
        MODE_LOOP: bus.tdo = (sdr_rises == 0) ? 1'b0 : tdi_seen[sdr_rises-1];
        MODE_ONES: bus.tdo = 1'b1;
        default:   bus.tdo = (sdr_rises < SRW) ? pat[sdr_rises] : 1'b0;
      endcase
      @(negedge clk);
      lat++;
    end

    check({tag, " latency"}, lat, SCAN_CLKS);
    exp_w = exp_q.pop_front();
    if (!bus.rsp_valid) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    check({tag, " rsp_dr"}, bus.rsp_dr, exp_w);
    check({tag, " tdi stream"}, tdi_seen, dr);
    check({tag, " sdr bits"}, sdr_rises, SRW);
    check({tag, " tck periods"}, all_rises, SRW + 4);
    check({tag, " vs_sdr clks"}, c_sdr, SRW * PER);
    check({tag, " uir/cdr/udr/rti clks"}, {16'(c_uir), 16'(c_cdr), 16'(c_udr), 16'(c_rti)},
          {16'(PER), 16'(PER), 16'(PER), 16'(PER)});
    check({tag, " ir_in during uir"}, bad_ir, 0);
    check({tag, " strobe overlap"}, bad_hot, 0);
    check({tag, " tdi outside sdr"}, bad_tdi, 0);
    check({tag, " cmd_ready while busy"}, bad_rdy, 0);

    snap = bus.rsp_dr;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_dr !== snap || bus.tck || bus.vs_uir || bus.vs_cdr ||
          bus.vs_sdr || bus.vs_udr || bus.jtag_rti || bus.cmd_ready) bad_hold++;
    end
    if (hold > 1) check({tag, " done hold"}, bad_hold, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
    check({tag, " ready after done"}, bus.cmd_ready, 1);
    check({tag, " rsp_dr held"}, bus.rsp_dr, snap);
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[5];
    logic [63:0] r64;
    logic [SRW-1:0] rdr, rpat, ndr;
    logic [IRW-1:0] rir;
    int rmode, rhold, w, rises;
    logic prev_tck;

    vecs[0] = '{ir: 2'b01, dr: 38'h2A_5A5A_5A5A, mode: MODE_LOOP, pat: '0,
                hold: 2, exp_rsp: 38'h14_B4B4_B4B4};
    vecs[1] = '{ir: 2'b10, dr: 38'h00_0000_0000, mode: MODE_ONES, pat: '0,
                hold: 20, exp_rsp: 38'h3F_FFFF_FFFF};
    vecs[2] = '{ir: 2'b11, dr: 38'h3F_FFFF_FFFF, mode: MODE_PAT, pat: 38'h00_0000_0001,
                hold: 0, exp_rsp: 38'h00_0000_0001};
    vecs[3] = '{ir: 2'b00, dr: 38'h20_0000_0001, mode: MODE_LOOP, pat: '0,
                hold: 1, exp_rsp: 38'h00_0000_0002};
    vecs[4] = '{ir: 2'b10, dr: 38'h15_5555_5555, mode: MODE_PAT, pat: 38'h2A_AAAA_AAAA,
                hold: 3, exp_rsp: 38'h2A_AAAA_AAAA};

    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = '0;
    bus.cmd_dr    = '0;
    bus.rsp_ready = 1'b0;
    bus.tdo       = 1'b0;

    // reset
    #2 reset_n = 1'b0;
    #1 check_reset_values("reset async");
    repeat (3) @(negedge clk);
    check_reset_values("reset held");
    reset_n = 1'b1;
    @(negedge clk);

    // directed table
    foreach (vecs[i])
      run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].dr, vecs[i].mode, vecs[i].pat,
               vecs[i].hold, vecs[i].exp_rsp, 1'b0, '0, '0);

    // second command held valid through the whole first scan
    ndr = 38'h0C_3C3C_0F0F;
    run_scan("chain A", 2'b01, 38'h12_3456_789A, MODE_PAT, 38'h31_0F0F_F0F0, 4,
             38'h31_0F0F_F0F0, 1'b1, 2'b10, ndr);
    run_scan("chain B", 2'b10, ndr, MODE_LOOP, '0, 2, model_rsp(MODE_LOOP, ndr, '0),
             1'b0, '0, '0);

    // randomized scans against the reference model
    for (int n = 0; n < 6; n++) begin
      r64   = {$urandom, $urandom};
      rdr   = r64[SRW-1:0];
      r64   = {$urandom, $urandom};
      rpat  = r64[SRW-1:0];
      rir   = IRW'($urandom_range(0, 3));
      rmode = $urandom_range(0, 2);
      rhold = $urandom_range(0, 4);
      run_scan($sformatf("rand%0d", n), rir, rdr, rmode, rpat, rhold,
               model_rsp(rmode, rdr, rpat), 1'b0, '0, '0);
    end

    // reset in the middle of the shift (during bit 10)
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = 2'b11;
    bus.cmd_dr    = 38'h3F_0000_FFFF;
    bus.rsp_ready = 1'b0;
    bus.tdo       = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rises = 0;
    w = 0;
    prev_tck = bus.tck;
    while (rises < 11 && w < 300) begin
      @(negedge clk);
      if (bus.tck && !prev_tck && bus.vs_sdr) rises++;
      prev_tck = bus.tck;
      w++;
    end
    check("mid-sdr reached bit 10", rises, 11);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid-scan reset");
    @(negedge clk);
    reset_n = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.cmd_ready || bus.tck) w++;
    end
    check("no partial response", w, 0);
    bus.tdo = 1'b0;
    run_scan("after reset", 2'b01, 38'h2A_5A5A_5A5A, MODE_LOOP, '0, 1,
             model_rsp(MODE_LOOP, 38'h2A_5A5A_5A5A, '0), 1'b0, '0, '0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
